// File: rtl/engine_cmd_frontend.sv
// rtl/engine_cmd_frontend.sv - engine-side command FIFO and exec_start/exec_done sequencer
// Optional watchdog enabled by defining ENGINE_FRONTEND_WATCHDOG_EN.
module engine_cmd_frontend #(
`ifdef ENGINE_FRONTEND_WATCHDOG_EN
  parameter int WD_CYCLES = 1024,
`endif
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_opcode,
  input  logic [3:0]       cmd_slot,
  input  logic [47:0]      cmd_dma_addr,
  output logic             engine_ready,
  output logic             exec_start,
  output logic [7:0]       exec_opcode,
  output logic [3:0]       exec_slot,
  output logic [47:0]      exec_dma_addr,
  input  logic             exec_done,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow_err,
`ifdef ENGINE_FRONTEND_WATCHDOG_EN
  output logic             wd_timeout,
`endif
  output logic [15:0]      cmds_done
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 8 + 4 + 48;

  // S_ISSUE is the single exec_start cycle; exec_done is not accepted there
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state, state_next;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count, count_next;
  logic               full, push, pop, accept_done, wd_fire;

  assign fifo_level = count;
  assign full       = (count == LVL_W'(DEPTH));
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign push       = cmd_valid && (!full || pop);

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    accept_done = 1'b0;
    exec_start  = 1'b0;
    busy        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        exec_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (exec_done) begin
          accept_done = 1'b1;
          state_next  = S_IDLE;
        end else if (wd_fire) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_opcode, cmd_slot, cmd_dma_addr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      engine_ready <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      engine_ready <= (count_next < LVL_W'(DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cmd_valid && !push) begin
        overflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_opcode   <= '0;
      exec_slot     <= '0;
      exec_dma_addr <= '0;
      cmds_done     <= '0;
    end else begin
      if (pop) begin
        {exec_opcode, exec_slot, exec_dma_addr} <= mem[rd_ptr];
      end
      if (accept_done) begin
        cmds_done <= cmds_done + 16'd1;
      end
    end
  end

`ifdef ENGINE_FRONTEND_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt;

  // fires in the WD_CYCLES-th consecutive S_WAIT cycle
  assign wd_fire = (state == S_WAIT) && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt     <= '0;
      wd_timeout <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire && !exec_done) begin
        wd_timeout <= 1'b1;
      end
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_engine_cmd_frontend.sv
// tb/tb_engine_cmd_frontend.sv - queue-model bench with per-cycle compare and literal pins
module tb_engine_cmd_frontend;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk, rst, cmd_valid, exec_done;
  logic [7:0]       cmd_opcode, exec_opcode;
  logic [3:0]       cmd_slot, exec_slot;
  logic [47:0]      cmd_dma_addr, exec_dma_addr;
  logic             engine_ready, exec_start, busy, overflow_err;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0]      cmds_done;
`ifdef ENGINE_FRONTEND_WATCHDOG_EN
  logic             wd_timeout;
`endif

  int n_cmp, n_fail;

  // model: queue of accepted commands plus engine phase (0 idle, 1 start pulse, 2 waiting)
  logic [59:0] m_q [$];
  logic [59:0] m_cur;
  int          m_phase, m_wcnt, m_cmds;
  bit          m_ovf, m_ready;
  logic [7:0]  issued [$];
  bit          auto_done;
  int          done_delay;

  engine_cmd_frontend #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_slot(cmd_slot), .cmd_dma_addr(cmd_dma_addr),
    .engine_ready(engine_ready), .exec_start(exec_start),
    .exec_opcode(exec_opcode), .exec_slot(exec_slot), .exec_dma_addr(exec_dma_addr),
    .exec_done(exec_done), .busy(busy), .fifo_level(fifo_level), .overflow_err(overflow_err),
`ifdef ENGINE_FRONTEND_WATCHDOG_EN
    .wd_timeout(wd_timeout),
`endif
    .cmds_done(cmds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] mk(input logic [7:0] o, input logic [3:0] s, input logic [47:0] a);
    return {o, s, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur   = '0;
    m_phase = 0;
    m_wcnt  = 0;
    m_cmds  = 0;
    m_ovf   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, push, done;
    if (rst) return;
    done = (m_phase == 2) && exec_done;
    pop  = (m_phase == 0) && (m_q.size() != 0);
    push = cmd_valid && ((m_q.size() < DEPTH) || pop);
    if (cmd_valid && !push) m_ovf = 1'b1;
    if (pop) m_cur = m_q.pop_front();
    if (push) m_q.push_back({cmd_opcode, cmd_slot, cmd_dma_addr});
    if (done) m_cmds = (m_cmds + 1) % 65536;
    case (m_phase)
      0: if (pop) m_phase = 1;
      1: begin m_phase = 2; m_wcnt = 1; end
      default: if (done) m_phase = 0; else m_wcnt++;
    endcase
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic compare_all();
    chk("engine_ready",  64'(engine_ready),  64'(m_ready));
    chk("fifo_level",    64'(fifo_level),    64'(m_q.size()));
    chk("exec_start",    64'(exec_start),    64'(m_phase == 1));
    chk("busy",          64'(busy),          64'(m_phase == 2));
    chk("exec_opcode",   64'(exec_opcode),   64'(m_cur[59:52]));
    chk("exec_slot",     64'(exec_slot),     64'(m_cur[51:48]));
    chk("exec_dma_addr", 64'(exec_dma_addr), 64'(m_cur[47:0]));
    chk("overflow_err",  64'(overflow_err),  64'(m_ovf));
    chk("cmds_done",     64'(cmds_done),     64'(m_cmds));
    if (exec_start === 1'b1) issued.push_back(exec_opcode);
  endtask

  // one clock cycle: drive inputs, compare at negedge, advance model at posedge
  task automatic step(input bit v, input logic [59:0] c);
    cmd_valid = v;
    {cmd_opcode, cmd_slot, cmd_dma_addr} = v ? c : 60'h0;
    exec_done = auto_done && !rst && (m_phase == 2) && (m_wcnt >= done_delay);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 60'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    issued.delete();
    idle(n);
    rst = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (!(m_phase == 0 && m_q.size() == 0) && k < limit) begin
      step(1'b0, 60'h0);
      k++;
    end
    chk("drain_bound", 64'(k < limit), 64'd1);
  endtask

  task automatic check_order(input logic [7:0] exp_ops [6], input int n);
    logic [7:0] g;
    chk("order_count", 64'(issued.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < issued.size()) ? issued[i] : 8'hEE;
      chk("order_op", 64'(g), 64'(exp_ops[i]));
    end
  endtask

  initial begin
    logic [7:0] ord [6];
    int k;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_opcode = '0;
    cmd_slot = '0;
    cmd_dma_addr = '0;
    exec_done = 1'b0;
    auto_done = 1'b0;
    done_delay = 3;
    model_reset();
    @(posedge clk);
    #1;

    idle(2);
    chk("rst_ready", 64'(engine_ready), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0;
    chk("ready_at_release", 64'(engine_ready), 64'd0);
    idle(1);
    chk("ready_after_release", 64'(engine_ready), 64'd1);
    chk("no_start_idle", 64'(exec_start), 64'd0);
    idle(2);

    // single command at t, exec_done at t+5
    auto_done = 1'b1;
    done_delay = 3;
    step(1'b1, mk(8'h11, 4'h3, 48'h0000_1234_5678));
    idle(1);
    chk("t2_start", 64'(exec_start), 64'd1);
    chk("t2_opcode", 64'(exec_opcode), 64'h11);
    chk("t2_slot", 64'(exec_slot), 64'h3);
    chk("t2_addr", 64'(exec_dma_addr), 64'h0000_1234_5678);
    chk("t2_busy", 64'(busy), 64'd0);
    idle(1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_start", 64'(exec_start), 64'd0);
    idle(2);
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_addr_held", 64'(exec_dma_addr), 64'h0000_1234_5678);
    chk("t5_cmds", 64'(cmds_done), 64'd0);
    idle(1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_cmds", 64'(cmds_done), 64'd1);

    // fill with exec_done held off, then overflow
    issued.delete();
    auto_done = 1'b0;
    step(1'b1, mk(8'h21, 4'h1, 48'h100));
    chk("fill_lvl1", 64'(fifo_level), 64'd1);
    step(1'b1, mk(8'h22, 4'h2, 48'h200));
    chk("fill_lvl_pop", 64'(fifo_level), 64'd1);
    step(1'b1, mk(8'h00, 4'h3, 48'h300));
    chk("fill_lvl2", 64'(fifo_level), 64'd2);
    step(1'b1, mk(8'h24, 4'h4, 48'h400));
    chk("fill_lvl3", 64'(fifo_level), 64'd3);
    step(1'b1, mk(8'h25, 4'h5, 48'hFFFF_FFFF_FFFF));
    chk("fill_lvl4", 64'(fifo_level), 64'd4);
    chk("fill_not_ready", 64'(engine_ready), 64'd0);
    step(1'b1, mk(8'h26, 4'h6, 48'h600));
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_lvl", 64'(fifo_level), 64'd4);
    idle(3);
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
    auto_done = 1'b1;
    done_delay = 1;
    drain(60);
    chk("ovf_cmds", 64'(cmds_done), 64'd6);
    chk("ovf_still", 64'(overflow_err), 64'd1);
    ord = '{8'h21, 8'h22, 8'h00, 8'h24, 8'h25, 8'h00};
    check_order(ord, 5);

    // push coincident with pop on a full FIFO
    do_reset(2);
    idle(1);
    auto_done = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, mk(8'h31 + 8'(i), 4'(i), 48'(i * 16)));
    auto_done = 1'b1;
    done_delay = 1;
    k = 0;
    while (!(m_phase == 0 && m_q.size() == DEPTH) && k < 10) begin
      step(1'b0, 60'h0);
      k++;
    end
    chk("coinc_full", 64'(fifo_level), 64'd4);
    step(1'b1, mk(8'h3F, 4'hF, 48'hABCD));
    chk("coinc_lvl", 64'(fifo_level), 64'd4);
    chk("coinc_no_ovf", 64'(overflow_err), 64'd0);
    drain(60);
    chk("coinc_cmds", 64'(cmds_done), 64'd6);
    ord = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h3F};
    check_order(ord, 6);

    // reset mid-operation discards everything
    auto_done = 1'b0;
    step(1'b1, mk(8'h41, 4'h1, 48'h1));
    step(1'b1, mk(8'h42, 4'h2, 48'h2));
    step(1'b1, mk(8'h43, 4'h3, 48'h3));
    idle(2);
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset(1);
    auto_done = 1'b1;
    idle(6);
    chk("post_rst_lvl", 64'(fifo_level), 64'd0);
    chk("post_rst_cmds", 64'(cmds_done), 64'd0);
    chk("post_rst_no_start", 64'(issued.size()), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/engine_cmd_frontend.md
Name: engine_cmd_frontend

Overview:
- Engine-side receiver for the command-dispatch interface driven by the command processor. One instance sits in front of each engine core (core 0 and core 1).
- Accepts single-cycle dispatched commands (opcode, slot, 48-bit DMA address) and buffers them in a small FIFO.
- Drives the engine_ready back-pressure signal.
- Sequences execution to the engine datapath with an exec_start/exec_done handshake, one command at a time.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- LVL_W, $clog2(DEPTH)+1, width of the fifo_level output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  one-cycle pulse: command fields valid this cycle.
- cmd_opcode  input  8  command opcode.
- cmd_slot  input  4  operand/buffer slot.
- cmd_dma_addr  input  48  DMA address.
- engine_ready  output  1  registered; high when at least one FIFO entry is free.
- exec_start  output  1  one-cycle pulse to the datapath.
- exec_opcode  output  8  held stable from exec_start until exec_done.
- exec_slot  output  4  held stable likewise.
- exec_dma_addr  output  48  held stable likewise.
- exec_done  input  1  datapath completion pulse.
- busy  output  1  high in the S_WAIT state.
- fifo_level  output  LVL_W  current FIFO occupancy.
- overflow_err  output  1  sticky; a command arrived while the FIFO was full.
- cmds_done  output  16  count of completed commands, wraps.

Behaviour:
- Reset values (async): FIFO empty, fifo_level=0, engine_ready=0, exec_start=0, exec_* fields=0, busy=0, overflow_err=0, cmds_done=0, state=S_IDLE.
- Reset mid-operation discards all buffered and in-flight commands. No exec_done is expected after reset.
- engine_ready:
  - Registered each cycle as (next occupancy < DEPTH).
  - Goes to 1 on the first clock edge after reset deassertion.
  - Reflects a push on the cycle after cmd_valid, so the dispatcher's next FETCH check sees the updated value.
- Push:
  - On cmd_valid with FIFO not full, {opcode, slot, addr} are written at the write pointer, which then increments (wraps at DEPTH).
  - Fields are sampled only in the cmd_valid cycle.
- Overflow:
  - cmd_valid with FIFO full (and no pop in the same cycle) drops the command and sets overflow_err.
  - overflow_err is cleared only by reset.
  - A push coincident with a pop on a full FIFO is accepted; no error.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- State machine:
  - S_IDLE: when the FIFO is non-empty, pop the head into the exec_* registers, pulse exec_start for one cycle, and go to S_WAIT. Otherwise stay in S_IDLE.
  - S_WAIT: busy=1, exec_start=0, exec_* held. On exec_done, increment cmds_done (16-bit wrap 0xFFFF->0) and go to S_IDLE.
- exec_done is ignored in S_IDLE and in the exec_start cycle itself. The minimum datapath latency is 1 cycle after exec_start.
- Latency:
  - cmd_valid at cycle t into an empty FIFO in S_IDLE -> exec_start high at t+2.
  - Back-to-back: exec_done at cycle u with a non-empty FIFO -> next exec_start at u+2 (one S_IDLE cycle).
- Ordering: strict FIFO; no reordering or opcode filtering. Opcode 0x00 is passed through like any other opcode.
- fifo_level is the registered occupancy, 0..DEPTH.

Optional Feature:
- Macro: ENGINE_FRONTEND_WATCHDOG_EN.
- With the macro defined:
  - Adds parameter WD_CYCLES (default 1024) and output wd_timeout (1-bit, sticky, reset 0).
  - A counter runs in S_WAIT. If it reaches WD_CYCLES without exec_done, wd_timeout is set and the FSM forcibly returns to S_IDLE without incrementing cmds_done.
  - A late exec_done is then ignored.
- Without the macro: no counter, no wd_timeout port, and S_WAIT waits indefinitely.

Test Plan:
- Reset then idle -> engine_ready=0 during reset and 1 one cycle after release; fifo_level=0; no exec_start.
- Single command (opcode 0x11, slot 3, addr 0x0000_1234_5678) at t, exec_done at t+5 -> exec_start at t+2 with matching fields held through t+5; busy high t+3..t+5; cmds_done=1.
- DEPTH=4, exec_done held off, 4 commands pushed -> fifo_level goes 1..3 then stays 3 after the first pop (cmds 2-4 buffered); after the 5th push fifo_level=4 and engine_ready=0 the next cycle.
- Overflow: push while full with no pop -> command dropped, overflow_err=1 and stays 1; subsequent execution order is cmds 1..5 with the dropped one absent.
- Push coincident with pop on a full FIFO -> accepted, no overflow_err, fifo_level unchanged; order preserved.
- Watchdog (macro on, WD_CYCLES=8): no exec_done after exec_start -> wd_timeout=1 at the 8th S_WAIT cycle, next command issued 2 cycles later, cmds_done unchanged.
